// File: rtl/sc_obstacle_spawner.sv
// Obstacle row generator for the road game: emits one road row per game tick,
// placing an obstacle in a pseudo-random lane once the minimum gap has elapsed.
module sc_obstacle_spawner #(
  parameter int OBSTACLE_MINGAP = 3
) (
  input  logic       SC_OBSTACLE_SPAWNER_CLOCK_50,
  input  logic       SC_OBSTACLE_SPAWNER_RESET_InHigh,
  input  logic       SC_OBSTACLE_SPAWNER_enable_InHigh,
  input  logic       SC_OBSTACLE_SPAWNER_tick_InHigh,
  input  logic [3:0] SC_OBSTACLE_SPAWNER_random_InBUS,
  output logic [7:0] SC_OBSTACLE_SPAWNER_row_OutBUS,
  output logic       SC_OBSTACLE_SPAWNER_rowValid_OutHigh,
  output logic       SC_OBSTACLE_SPAWNER_randNext_OutHigh,
  output logic [7:0] SC_OBSTACLE_SPAWNER_spawnCount_OutBUS
);

  localparam logic [3:0] MinGap = 4'(OBSTACLE_MINGAP);

  typedef enum logic [1:0] {IDLE, COUNT, EMIT} stateT;

  stateT      state;
  logic [3:0] gapCnt;
  logic [2:0] lastLane;
  logic [2:0] laneNext;
  logic [3:0] gapReload;

  // Never repeat the previous lane: a collision is bumped to the next lane, wrapping 7 -> 0.
  always_comb begin
    laneNext  = SC_OBSTACLE_SPAWNER_random_InBUS[2:0];
    if (laneNext == lastLane)
      laneNext = lastLane + 3'd1;
    gapReload = MinGap + {2'b00, SC_OBSTACLE_SPAWNER_random_InBUS[3:2]};
  end

  always_ff @(posedge SC_OBSTACLE_SPAWNER_CLOCK_50) begin
    if (SC_OBSTACLE_SPAWNER_RESET_InHigh) begin
      state                                 <= IDLE;
      gapCnt                                <= MinGap;
      lastLane                              <= 3'd0;
      SC_OBSTACLE_SPAWNER_row_OutBUS        <= 8'h00;
      SC_OBSTACLE_SPAWNER_rowValid_OutHigh  <= 1'b0;
      SC_OBSTACLE_SPAWNER_randNext_OutHigh  <= 1'b0;
      SC_OBSTACLE_SPAWNER_spawnCount_OutBUS <= 8'h00;
    end else begin
      SC_OBSTACLE_SPAWNER_rowValid_OutHigh <= 1'b0;
      SC_OBSTACLE_SPAWNER_randNext_OutHigh <= 1'b0;
      case (state)
        IDLE: begin
          if (SC_OBSTACLE_SPAWNER_enable_InHigh) begin
            gapCnt <= MinGap;
            state  <= COUNT;
          end
        end
        COUNT: begin
          if (!SC_OBSTACLE_SPAWNER_enable_InHigh) begin
            state <= IDLE;
          end else if (SC_OBSTACLE_SPAWNER_tick_InHigh) begin
            // Outputs are registered here so they are presented during the EMIT cycle.
            state                                <= EMIT;
            SC_OBSTACLE_SPAWNER_rowValid_OutHigh <= 1'b1;
            if (gapCnt == 4'd0) begin
              SC_OBSTACLE_SPAWNER_row_OutBUS       <= 8'd1 << laneNext;
              SC_OBSTACLE_SPAWNER_randNext_OutHigh <= 1'b1;
              lastLane                             <= laneNext;
              gapCnt                               <= gapReload;
              if (SC_OBSTACLE_SPAWNER_spawnCount_OutBUS != 8'hFF)
                SC_OBSTACLE_SPAWNER_spawnCount_OutBUS <= SC_OBSTACLE_SPAWNER_spawnCount_OutBUS + 8'd1;
            end else begin
              SC_OBSTACLE_SPAWNER_row_OutBUS <= 8'h00;
              gapCnt                         <= gapCnt - 4'd1;
            end
          end
        end
        EMIT: begin
          state <= SC_OBSTACLE_SPAWNER_enable_InHigh ? COUNT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
